// File: rtl/pic_priority_resolver.sv
// rtl/pic_priority_resolver.sv - 8259 IRR/ISR/priority stage; optional PIC_SPECIAL_MASK_EN adds smm
module pic_priority_resolver #(
    parameter int         NUM_IRQ  = 8,
    parameter logic [2:0] LP_RESET = 3'd7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] ir_in,
    input  logic               ltim,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic               inta_first,
    input  logic               inta_second,
    input  logic               aeoi,
    input  logic               auto_rotate,
    input  logic               eoi_valid,
    input  logic               eoi_specific,
    input  logic               eoi_rotate,
    input  logic [2:0]         eoi_level,
    input  logic               prio_set,
`ifdef PIC_SPECIAL_MASK_EN
    input  logic               smm,
`endif
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] isr,
    output logic               int_req,
    output logic [2:0]         highest_isr,
    output logic [2:0]         ack_id,
    output logic               spurious
);

    logic [2:0]         lp;
    logic [NUM_IRQ-1:0] ir_prev;

    // Returns {found, id}: first set bit scanning lp+1, lp+2, ..., lp.
    function automatic logic [3:0] pick(input logic [NUM_IRQ-1:0] v, input logic [2:0] base);
        logic [3:0] r;
        logic [2:0] idx;
        r = 4'd0;
        for (int k = 1; k <= NUM_IRQ; k++) begin
            idx = base + 3'(k);
            if (!r[3] && v[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    logic [3:0]         cand, hi, nest;
    logic [NUM_IRQ-1:0] nest_isr;
    logic [2:0]         rank_cand, rank_nest, eoi_target;
    logic               req_next, ack, eoi_act, aeoi_act;
    logic [NUM_IRQ-1:0] isr_set, isr_clr, irr_next;
    logic [2:0]         lp_next;

    always_comb begin
        nest_isr = isr;
`ifdef PIC_SPECIAL_MASK_EN
        if (smm) nest_isr = isr & ~imr;
`endif
        cand = pick(irr & ~imr, lp);
        hi   = pick(isr, lp);
        nest = pick(nest_isr, lp);

        // Rank 0 is the highest priority level (lp+1).
        rank_cand = cand[2:0] - lp - 3'd1;
        rank_nest = nest[2:0] - lp - 3'd1;
        req_next  = cand[3] && (!nest[3] || (rank_cand < rank_nest));

        ack        = inta_first && cand[3];
        eoi_target = eoi_specific ? eoi_level : nest[2:0];
        eoi_act    = eoi_valid && (eoi_specific || nest[3]);
        aeoi_act   = inta_second && aeoi && !spurious;

        isr_set = ack ? (NUM_IRQ'(1) << cand[2:0]) : '0;
        isr_clr = '0;
        if (eoi_act)  isr_clr = isr_clr | (NUM_IRQ'(1) << eoi_target);
        if (aeoi_act) isr_clr = isr_clr | (NUM_IRQ'(1) << ack_id);

        irr_next = ltim ? ir_in : (irr | (ir_in & ~ir_prev));
        if (ack) irr_next[cand[2:0]] = 1'b0;

        lp_next = lp;
        if (prio_set)                      lp_next = eoi_level;
        else if (eoi_act && eoi_rotate)    lp_next = eoi_target;
        else if (aeoi_act && auto_rotate)  lp_next = ack_id;
    end

    assign highest_isr = hi[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            irr      <= '0;
            isr      <= '0;
            lp       <= LP_RESET;
            int_req  <= 1'b0;
            ack_id   <= 3'd0;
            spurious <= 1'b0;
            ir_prev  <= '0;
        end else begin
            ir_prev <= ir_in;
            irr     <= irr_next;
            // Set wins over clear when the same bit is hit by both.
            isr     <= (isr & ~isr_clr) | isr_set;
            lp      <= lp_next;
            int_req <= inta_first ? 1'b0 : req_next;
            if (inta_first) begin
                ack_id   <= cand[3] ? cand[2:0] : 3'd7;
                spurious <= ~cand[3];
            end
        end
    end

endmodule
